// File: rtl/frequency_verdict_collector_pkg.sv
// freq_verdict_pkg: verdict codes, FSM states and record-width helpers for frequency_verdict_collector.
// TS_BITS follows VERDICT_TIMESTAMP_EN so every record user sizes itself the same way.
package freq_verdict_pkg;
   localparam logic [1:0] VERDICT_NONE  = 2'b00;
   localparam logic [1:0] VERDICT_F1    = 2'b01;
   localparam logic [1:0] VERDICT_F2    = 2'b10;
   localparam logic [1:0] VERDICT_AMBIG = 2'b11;
   typedef enum logic [1:0] {ST_IDLE, ST_LATCH, ST_SCAN, ST_DONE} state_e;
`ifdef VERDICT_TIMESTAMP_EN
   localparam int TS_BITS = 32;
`else
   localparam int TS_BITS = 0;
`endif
   function automatic int chan_width(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
   function automatic int rec_width(input int n, input int cw);
      return chan_width(n) + 2 + cw + TS_BITS;
   endfunction
endpackage

// File: rtl/frequency_verdict_collector_fifo.sv
// verdict_fifo: first-word-fall-through FIFO; a push into a full FIFO is taken when a pop happens the same cycle.
module verdict_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign empty_o = cnt_q == '0;
   assign full_o  = cnt_q == (AW+1)'(DEPTH);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign data_o  = mem_q[rd_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= wr_q + 1'b1;
         end
         if (do_pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/frequency_verdict_collector.sv
// frequency_verdict_collector: on each window strobe, classifies every channel's f1/f2 counts and queues one record per channel.
// Define VERDICT_TIMESTAMP_EN to tag records with the cycle counter value at LATCH on result_timestamp.
module frequency_verdict_collector
   import freq_verdict_pkg::*;
#(
   parameter int NUM_CHANNELS = 3,
   parameter int COUNT_WIDTH  = 32,
   parameter int MIN_COUNT    = 16,
   parameter int RATIO_SHIFT  = 1,
   parameter int FIFO_DEPTH   = 4,
   localparam int CH_W = chan_width(NUM_CHANNELS)
) (
   input  logic                                clock,
   input  logic                                clear,
   input  logic                                enable,
   input  logic                                window_done,
   input  logic [NUM_CHANNELS*COUNT_WIDTH-1:0] f1_values,
   input  logic [NUM_CHANNELS*COUNT_WIDTH-1:0] f2_values,
   output logic                                result_valid,
   input  logic                                result_ready,
   output logic [CH_W-1:0]                     result_channel,
   output logic [1:0]                          result_code,
   output logic [COUNT_WIDTH-1:0]              result_value,
`ifdef VERDICT_TIMESTAMP_EN
   output logic [31:0]                         result_timestamp,
`endif
   output logic                                busy,
   output logic                                overflow,
   output logic [15:0]                         window_count
);
   localparam int REC_W = rec_width(NUM_CHANNELS, COUNT_WIDTH);
   localparam logic [COUNT_WIDTH-1:0] MIN_C = COUNT_WIDTH'(MIN_COUNT);
   localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CHANNELS - 1);

   state_e                 state_q;
   logic [COUNT_WIDTH-1:0] f1_q [NUM_CHANNELS];
   logic [COUNT_WIDTH-1:0] f2_q [NUM_CHANNELS];
   logic [CH_W-1:0]        idx_q;
   logic                   overflow_q;
   logic [15:0]            window_count_q;
   logic                   push, pop, full, empty, pa, pb;
   logic [COUNT_WIDTH-1:0] a, b, value;
   logic [COUNT_WIDTH:0]   a_thr, b_thr;
   logic [1:0]             code;
   logic [REC_W-1:0]       rec_in, rec_out;

   assign a     = f1_q[idx_q];
   assign b     = f2_q[idx_q];
   assign pa    = a >= MIN_C;
   assign pb    = b >= MIN_C;
   // Margins are formed one bit wider so a near-full count cannot wrap past its rival.
   assign a_thr = {1'b0, a} + ({1'b0, a} >> RATIO_SHIFT);
   assign b_thr = {1'b0, b} + ({1'b0, b} >> RATIO_SHIFT);

   always_comb begin
      code  = !pa && !pb          ? VERDICT_NONE  :
              !pb                 ? VERDICT_F1    :
              !pa                 ? VERDICT_F2    :
              {1'b0, a} > b_thr   ? VERDICT_F1    :
              {1'b0, b} > a_thr   ? VERDICT_F2    : VERDICT_AMBIG;
      value = code == VERDICT_NONE ? '0 :
              code == VERDICT_F1   ? a  :
              code == VERDICT_F2   ? b  : (a > b ? a : b);
   end

   assign pop          = result_valid & result_ready;
   assign push         = state_q == ST_SCAN && (!full || pop);
   assign result_valid = ~empty;
   assign busy         = state_q != ST_IDLE;
   assign overflow     = overflow_q;
   assign window_count = window_count_q;

`ifdef VERDICT_TIMESTAMP_EN
   logic [31:0] cycle_q, stamp_q;
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) cycle_q <= '0;
      else cycle_q <= cycle_q + 32'd1;
   end
   assign rec_in = {stamp_q, idx_q, code, value};
   assign {result_timestamp, result_channel, result_code, result_value} = rec_out;
`else
   assign rec_in = {idx_q, code, value};
   assign {result_channel, result_code, result_value} = rec_out;
`endif

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q        <= ST_IDLE;
         idx_q          <= '0;
         overflow_q     <= 1'b0;
         window_count_q <= '0;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            f1_q[i] <= '0;
            f2_q[i] <= '0;
         end
`ifdef VERDICT_TIMESTAMP_EN
         stamp_q <= '0;
`endif
      end else begin
         if (window_done && enable && state_q != ST_IDLE) overflow_q <= 1'b1;
         case (state_q)
            ST_IDLE: if (window_done && enable) begin
               // Counts are only guaranteed stable in the strobe cycle, so the shadow loads on that edge.
               for (int i = 0; i < NUM_CHANNELS; i++) begin
                  f1_q[i] <= f1_values[i*COUNT_WIDTH +: COUNT_WIDTH];
                  f2_q[i] <= f2_values[i*COUNT_WIDTH +: COUNT_WIDTH];
               end
               state_q <= ST_LATCH;
            end
            ST_LATCH: begin
               idx_q   <= '0;
`ifdef VERDICT_TIMESTAMP_EN
               stamp_q <= cycle_q;
`endif
               state_q <= ST_SCAN;
            end
            ST_SCAN: if (push) begin
               idx_q   <= idx_q + 1'b1;
               state_q <= idx_q == LAST ? ST_DONE : ST_SCAN;
            end
            default: begin
               window_count_q <= window_count_q + 16'd1;
               state_q        <= ST_IDLE;
            end
         endcase
      end
   end

   verdict_fifo #(.WIDTH(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clock),
      .rst_n  (clear),
      .push_i (push),
      .pop_i  (pop),
      .data_i (rec_in),
      .data_o (rec_out),
      .full_o (full),
      .empty_o(empty)
   );
endmodule

// File: tb/tb_frequency_verdict_collector.sv
// tb_frequency_verdict_collector: directed windows with hand-computed verdicts for frequency_verdict_collector.
module tb_frequency_verdict_collector;
   logic        clock = 0, clear = 0, enable = 1, window_done = 0, result_ready = 0;
   logic [95:0] f1_values = '0, f2_values = '0;
   logic        result_valid, busy, overflow;
   logic [1:0]  result_channel, result_code;
   logic [31:0] result_value;
   logic [15:0] window_count;
`ifdef VERDICT_TIMESTAMP_EN
   logic [31:0] result_timestamp;
`endif
   int n_chk = 0, n_pass = 0, exp_wc = 0;

   frequency_verdict_collector dut (
      .clock(clock), .clear(clear), .enable(enable), .window_done(window_done),
      .f1_values(f1_values), .f2_values(f2_values),
      .result_valid(result_valid), .result_ready(result_ready),
      .result_channel(result_channel), .result_code(result_code), .result_value(result_value),
`ifdef VERDICT_TIMESTAMP_EN
      .result_timestamp(result_timestamp),
`endif
      .busy(busy), .overflow(overflow), .window_count(window_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic set_ch(input int c, input logic [31:0] a, input logic [31:0] b);
      f1_values[c*32 +: 32] = a;
      f2_values[c*32 +: 32] = b;
   endtask

   task automatic strobe();
      @(negedge clock) window_done = 1;
      @(negedge clock) window_done = 0;
   endtask

   task automatic pop_rec(input string tag, input logic [1:0] ch, input logic [1:0] code, input logic [31:0] val);
      for (int i = 0; i < 20 && !result_valid; i++) @(negedge clock);
      chk({tag, "_vld"}, result_valid, 1);
      chk({tag, "_ch"}, result_channel, ch);
      chk({tag, "_code"}, result_code, code);
      chk({tag, "_val"}, result_value, val);
      result_ready = 1;
      @(negedge clock) result_ready = 0;
   endtask

   task automatic settle_wc(input string tag);
      repeat (6) @(negedge clock);
      chk({tag, "_wc"}, window_count, exp_wc);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_empty"}, result_valid, 0);
   endtask

   task automatic default_window();
      set_ch(0, 100, 10);
      set_ch(1, 0, 0);
      set_ch(2, 40, 50);
   endtask

   initial begin
      repeat (2) @(negedge clock);
      chk("rst_valid", result_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_wc", window_count, 0);
      chk("rst_rec", {result_channel, result_code, result_value}, 0);
      clear = 1;

      default_window();
      strobe();
      chk("lat_busy_c1", busy, 1);
      chk("lat_valid_c1", result_valid, 0);
      @(negedge clock) chk("lat_valid_c2", result_valid, 0);
      @(negedge clock) chk("lat_valid_c3", result_valid, 1);
      pop_rec("w1r0", 0, 2'b01, 100);
      pop_rec("w1r1", 1, 2'b00, 0);
      pop_rec("w1r2", 2, 2'b11, 50);
      exp_wc++;
      settle_wc("w1");

      set_ch(0, 20, 100); set_ch(1, 15, 16); set_ch(2, 15, 15);
      strobe();
      pop_rec("w2r0", 0, 2'b10, 100);
      pop_rec("w2r1", 1, 2'b10, 16);
      pop_rec("w2r2", 2, 2'b00, 0);
      exp_wc++;
      settle_wc("w2");

      set_ch(0, 31, 20); set_ch(1, 30, 20); set_ch(2, 16, 16);
      strobe();
      pop_rec("w3r0", 0, 2'b01, 31);
      pop_rec("w3r1", 1, 2'b11, 30);
      pop_rec("w3r2", 2, 2'b11, 16);
      exp_wc++;
      settle_wc("w3");

      set_ch(0, 32'hFFFF_FFFF, 32'hFFFF_FFF0); set_ch(1, 32'hFFFF_FFFF, 0); set_ch(2, 16, 32'hFFFF_FFFF);
      strobe();
      pop_rec("w4r0", 0, 2'b11, 32'hFFFF_FFFF);
      pop_rec("w4r1", 1, 2'b01, 32'hFFFF_FFFF);
      pop_rec("w4r2", 2, 2'b10, 32'hFFFF_FFFF);
      exp_wc++;
      settle_wc("w4");

      default_window();
      strobe();
      repeat (8) @(negedge clock);
      set_ch(1, 8, 17);
      strobe();
      repeat (10) @(negedge clock);
      chk("full_busy", busy, 1);
      chk("full_valid", result_valid, 1);
      chk("full_ovf", overflow, 0);
      chk("full_wc", window_count, exp_wc + 1);
      pop_rec("fr0", 0, 2'b01, 100);
      pop_rec("fr1", 1, 2'b00, 0);
      pop_rec("fr2", 2, 2'b11, 50);
      pop_rec("fr3", 0, 2'b01, 100);
      pop_rec("fr4", 1, 2'b10, 17);
      pop_rec("fr5", 2, 2'b11, 50);
      exp_wc += 2;
      settle_wc("full");

      enable = 0;
      strobe();
      chk("dis_busy", busy, 0);
      enable = 1;
      settle_wc("dis");

      default_window();
      strobe();
      @(negedge clock) window_done = 1;
      @(negedge clock) window_done = 0;
      pop_rec("ovr0", 0, 2'b01, 100);
      pop_rec("ovr1", 1, 2'b00, 0);
      pop_rec("ovr2", 2, 2'b11, 50);
      exp_wc++;
      settle_wc("ovr");
      chk("ovr_flag", overflow, 1);

      strobe();
      @(negedge clock) clear = 0;
      #1;
      chk("clr_valid", result_valid, 0);
      chk("clr_busy", busy, 0);
      chk("clr_ovf", overflow, 0);
      chk("clr_wc", window_count, 0);
      @(negedge clock) clear = 1;
      exp_wc = 0;
      strobe();
      pop_rec("pc0", 0, 2'b01, 100);
      pop_rec("pc1", 1, 2'b00, 0);
      pop_rec("pc2", 2, 2'b11, 50);
      exp_wc++;
      settle_wc("pc");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/frequency_verdict_collector.md
Name: frequency_verdict_collector

Overview:
- Downstream consumer of the per-pixel frequency analyzers.
- On each measurement-window strobe, snapshots every channel's f1/f2 action-time counts and classifies each channel as none / f1 / f2 / ambiguous.
- Pushes one result record per channel into a small FIFO, read out with a valid/ready handshake; feeds the future AXI slave/readout stage.

Parameters:
- NUM_CHANNELS, 3, number of analyzed pixels (channel 0..NUM_CHANNELS-1).
- COUNT_WIDTH, 32, width of each f1/f2 action-time count.
- MIN_COUNT, 16, minimum count for a frequency to be "present".
- RATIO_SHIFT, 1, dominance margin: winner must exceed loser + (loser >> RATIO_SHIFT).
- FIFO_DEPTH, 4, result FIFO entries (power of 2, >= 2).

Ports:
- clock  in  1  single clock for all logic.
- clear  in  1  reset, asynchronous, active-low.
- enable  in  1  accept new windows when high.
- window_done  in  1  one-cycle strobe; count inputs valid and stable this cycle.
- f1_values  in  NUM_CHANNELS*COUNT_WIDTH  packed f1 counts, channel 0 in LSBs.
- f2_values  in  NUM_CHANNELS*COUNT_WIDTH  packed f2 counts, channel 0 in LSBs.
- result_valid  out  1  FIFO non-empty.
- result_ready  in  1  consumer accepts the head record.
- result_channel  out  clog2(NUM_CHANNELS) (min 1)  channel index of the head record.
- result_code  out  2  00 none, 01 f1, 10 f2, 11 ambiguous.
- result_value  out  COUNT_WIDTH  winning / max count; 0 for none.
- busy  out  1  FSM not IDLE.
- overflow  out  1  sticky: window_done seen while busy and enable high.
- window_count  out  16  completed windows, wraps 0xFFFF -> 0.

Behaviour:
- Reset (clear=0, async): FSM IDLE, FIFO empty, all outputs 0, shadow registers 0.
- FSM states: IDLE, LATCH, SCAN, DONE.
- IDLE -> LATCH: on window_done & enable.
- LATCH: copy all inputs to shadow registers (1 cycle); channel index = 0; -> SCAN.
- SCAN: classify shadow[idx]. Push the record when FIFO not full, or when full with a pop in the same cycle.
  - On push: idx++. After idx = NUM_CHANNELS-1 is pushed -> DONE.
  - If FIFO full with no pop: stall on the same idx.
- DONE: window_count++ -> IDLE.
- Latency, FIFO empty and ready high: strobe in cycle 0 -> LATCH cycle 1 -> first push end of cycle 2 -> result_valid high in cycle 3; one record per cycle after that.
- Classification, a=f1, b=f2; comparisons in COUNT_WIDTH+1 bits, no wrap:
  - pa = a>=MIN_COUNT, pb = b>=MIN_COUNT.
  - Neither present: code 00, value 0.
  - Only pa: 01, value a. Only pb: 10, value b.
  - Both present: a > b+(b>>RATIO_SHIFT) -> 01, value a; else b > a+(a>>RATIO_SHIFT) -> 10, value b; else 11, value max(a,b).
- FIFO: first-word-fall-through; pop on result_valid & result_ready; record order = push order.
- window_done while busy: ignored and overflow set, but only if enable high. Cleared only by reset.
- enable low mid-window: current scan completes; new strobes ignored, overflow untouched.

Optional Feature:
- Macro VERDICT_TIMESTAMP_EN.
- Defined: 32-bit free-running cycle counter (reset 0, wraps); its value at LATCH is stored with each record and appears on extra output result_timestamp [31:0].
- Not defined: no counter, no port, FIFO width unchanged.

Decomposition:
- Package freq_verdict_pkg holds:
  - code constants VERDICT_NONE/F1/F2/AMBIG;
  - FSM state encodings;
  - record-width helper constants.
- One sub-module: verdict_fifo (parameterized width/depth, FWFT, full/empty, simultaneous push+pop when full).

Test Plan:
- Defaults; ch0 f1=100,f2=10; ch1 0,0; ch2 40,50; strobe at cycle 0 -> records (0,01,100), (1,00,0), (2,11,50) in order; result_valid first high cycle 3; window_count=1.
- ch0 f1=20,f2=100 -> (0,10,100); ch0 f1=15,f2=16 -> (0,10,16).
- result_ready=0; two windows spaced 10 cycles apart -> FIFO full at 4, busy stays 1. Raise ready -> 6 records in order ch0,1,2,0,1,2; window_count=2.
- window_done pulsed during SCAN -> overflow=1, window_count increments once, no extra records.
- clear low mid-SCAN -> same edge: result_valid=0, busy=0, overflow=0, window_count=0. After release, a new window is processed normally.
- ch0 f1=0xFFFFFFFF, f2=0xFFFFFFF0 -> (0,11,0xFFFFFFFF), no arithmetic wrap.
